// File: rtl/pi_digit_stream_pkg.sv
// pi_digit_stream_pkg: shared constants, state type and BCD check for the pi digit streamer
package pi_digit_stream_pkg;
  localparam int DIGITS_PER_WORD = 9;
  localparam int BCD_W = 4;
  localparam int N_DEF = 6144;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = DIGITS_PER_WORD * BCD_W;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic bcd_bad(input logic [DATA_W_DEF-1:0] w);
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS_PER_WORD; i++)
      if (w[i*BCD_W +: BCD_W] > 4'd9) bcd_bad = 1'b1;
  endfunction
endpackage

// File: rtl/pi_digit_stream_fifo.sv
// pi_word_fifo: small synchronous word FIFO with synchronous clear and fall-through head
module pi_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  // pointer and occupancy update; clear wins over any traffic
  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assert property (@(posedge clk) disable iff (clr) !(push && !pop && count == (AW+1)'(DEPTH)));
  assert property (@(posedge clk) disable iff (clr) !(pop && count == '0));
endmodule

// File: rtl/pi_digit_stream.sv
// pi_digit_stream: drives the pi ROM, tracks its latency, buffers words and streams BCD digits
module pi_digit_stream import pi_digit_stream_pkg::*; #(
  parameter int N = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              dig_valid,
  input  logic              dig_ready,
  output logic [BCD_W-1:0]  dig,
  output logic              dig_first,
  output logic              bcd_err,
  output logic              busy
);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic iss_q, first_pend, flush, arrive, issue, last, xfer, need, load, push, pop, fempty;
  logic [RD_LAT-1:0] tag;
  logic [CW-1:0] in_flight;
  logic [FCW-1:0] fcount;
  logic [DATA_W-1:0] fdout, src, word_q;
  logic [3:0] cnt;
  assign busy = state == RUN;
  assign flush = start | stop;
  assign arrive = tag[RD_LAT-1];
  assign fempty = fcount == '0;
  assign last = cnt == 4'(DIGITS_PER_WORD - 1);
  assign xfer = dig_valid && dig_ready;
  assign need = !dig_valid || (xfer && last);
  assign src = fempty ? mem_data : fdout;
  assign load = !flush && need && (!fempty || arrive);
  assign push = arrive && !(load && fempty);
  assign pop = load && !fempty;
  assign issue = state == RUN && !flush && (in_flight + CW'(fcount) < CW'(FIFO_DEPTH));
  // reads outstanding: the address on the bus now plus every tagged stage still waiting
  always_comb begin
    in_flight = CW'(iss_q);
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(tag[i]);
  end
  pi_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk), .clr(rst | flush), .push(push), .pop(pop),
    .din(mem_data), .dout(fdout), .count(fcount)
  );
  // state, read address and tag pipe; a flush empties the pipe so stale words are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_addr <= '0;
      iss_q <= 1'b0;
      tag <= '0;
    end else if (start) begin
      state <= RUN;
      mem_addr <= start_addr;
      iss_q <= 1'b1;
      tag <= '0;
    end else if (stop) begin
      state <= IDLE;
      iss_q <= 1'b0;
      tag <= '0;
    end else begin
      tag <= {tag[RD_LAT-2:0], iss_q};
      iss_q <= issue;
      if (issue) mem_addr <= mem_addr == ADDR_W'(N - 1) ? '0 : mem_addr + ADDR_W'(1);
    end
  end
  // unpack stage: word arriving with an empty FIFO bypasses it so the first digit is not delayed
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_valid <= 1'b0;
      dig <= '0;
      dig_first <= 1'b0;
      bcd_err <= 1'b0;
      cnt <= '0;
      word_q <= '0;
      first_pend <= 1'b0;
    end else begin
      if (load && bcd_bad(src)) bcd_err <= 1'b1;
      if (flush) begin
        dig_valid <= 1'b0;
        dig_first <= 1'b0;
        cnt <= '0;
        first_pend <= start;
      end else if (load) begin
        dig_valid <= 1'b1;
        dig <= src[DATA_W-1 -: BCD_W];
        word_q <= src << BCD_W;
        cnt <= '0;
        dig_first <= first_pend;
        first_pend <= 1'b0;
      end else if (xfer) begin
        dig_valid <= !last;
        dig <= word_q[DATA_W-1 -: BCD_W];
        word_q <= word_q << BCD_W;
        cnt <= cnt + 4'd1;
        dig_first <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pi_digit_stream.sv
// tb_pi_digit_stream: randomized-backpressure bench with a digit-stream reference model
module tb_pi_digit_stream;
  localparam int N = 6144;
  localparam int RD_LAT = 3;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, start = 0, stop = 0, dig_ready = 1;
  logic [23:0] start_addr = '0, mem_addr;
  logic [35:0] mem_data, p1, p2, p3;
  logic dig_valid, dig_first, bcd_err, busy;
  logic [3:0] dig;
  int checks = 0, failures = 0;
  int base = 0, idx = 0, issued = 0, last_addr = 0, bad_k = -1;
  bit streaming = 0, rand_mode = 0, prev_stall = 0;
  logic [4:0] prev_out;
  logic [3:0] log_q[$];
  bit flog[$];
  int addr_log[$];
  logic [3:0] ref_log[27];

  pi_digit_stream dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .stop(stop),
    .mem_addr(mem_addr), .mem_data(mem_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig(dig), .dig_first(dig_first), .bcd_err(bcd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] rom(int k);
    logic [35:0] w;
    case (k)
      0: w = 36'h141592653;
      1: w = 36'h589793238;
      2: w = 36'h462643383;
      default: begin
        for (int i = 0; i < 9; i++) w[35-4*i -: 4] = 4'((k + 3*i) % 10);
        if (k == bad_k) w[19:16] = 4'hA;
      end
    endcase
    return w;
  endfunction

  function automatic logic [3:0] exp_digit(int i);
    logic [35:0] w;
    w = rom((base + i/9) % N);
    return w[35-4*(i%9) -: 4];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    p1 <= rom(int'(mem_addr));
    p2 <= p1;
    p3 <= p2;
  end
  assign mem_data = p3;

  always @(posedge clk) begin
    #2;
    dig_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && !streaming) begin
      chk("idle_valid", dig_valid, 0);
    end else if (!rst) begin
      int started;
      if (int'(mem_addr) != last_addr) begin
        chk("addr_seq", mem_addr, (last_addr + 1) % N);
        last_addr = int'(mem_addr);
        issued++;
        addr_log.push_back(last_addr);
      end
      started = dig_valid ? idx/9 + 1 : (idx + 8)/9;
      chk("outstanding", (issued - started) <= DEPTH, 1);
      if (prev_stall) begin
        chk("stall_valid", dig_valid, 1);
        chk("stall_out", {dig_first, dig}, prev_out);
      end
      if (dig_valid && dig_ready) begin
        chk("dig", dig, exp_digit(idx));
        chk("dig_first", dig_first, idx == 0);
        log_q.push_back(dig);
        flog.push_back(dig_first);
        idx++;
      end
      prev_stall = dig_valid && !dig_ready;
      prev_out = {dig_first, dig};
    end
  end

  task automatic do_start(input int a, input bit with_stop = 0);
    @(posedge clk);
    #2 start = 1; stop = with_stop; start_addr = 24'(a);
    @(posedge clk);
    #1 start = 0; stop = 0;
    streaming = 1; base = a; idx = 0; issued = 1; last_addr = a; prev_stall = 0;
    log_q.delete(); flog.delete(); addr_log.delete(); addr_log.push_back(a);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!dig_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, dig_valid, 0);
    chk({tag, "_dig"}, dig, 0);
    chk({tag, "_first"}, dig_first, 0);
    chk({tag, "_err"}, bcd_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bubbles, mism, ones, a;
    int pin[18] = '{1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8};
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 0;
    do_start(0);
    chk("busy_run", busy, 1);
    wait_valid(lat);
    chk("latency_start0", lat, RD_LAT + 1);
    bubbles = 0;
    repeat (26) begin
      @(posedge clk);
      #1 if (!dig_valid) bubbles++;
    end
    chk("no_bubble", bubbles, 0);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) chk("pi_digit", log_q[i], pin[i]);
    chk("first_flag0", flog[0], 1);
    ones = 0;
    for (int i = 1; i < 27; i++) ones += int'(flog[i]);
    chk("first_flag_rest", ones, 0);
    for (int i = 0; i < 27; i++) ref_log[i] = log_q[i];
    do_start(N - 1);
    repeat (20) @(posedge clk);
    #1;
    chk("wrap_d0", log_q[0], 3);
    chk("wrap_d8", log_q[8], 7);
    chk("wrap_next0", log_q[9], 1);
    chk("wrap_next1", log_q[10], 4);
    chk("wrap_addr0", addr_log[0], N - 1);
    chk("wrap_addr1", addr_log[1], 0);
    chk("wrap_addr2", addr_log[2], 1);
    rand_mode = 1;
    do_start(0);
    repeat (300) @(posedge clk);
    #1;
    rand_mode = 0;
    chk("bp_len", log_q.size() >= 27, 1);
    mism = 0;
    for (int i = 0; i < 27; i++) if (log_q[i] !== ref_log[i]) mism++;
    chk("bp_seq", mism, 0);
    do_start(0);
    repeat (2) @(posedge clk);
    do_start(10);
    wait_valid(lat);
    chk("restart_latency", lat, RD_LAT + 1);
    chk("restart_dig", dig, 0);
    chk("restart_first", dig_first, 1);
    repeat (12) @(posedge clk);
    @(posedge clk);
    #2 stop = 1; a = int'(mem_addr);
    chk("pre_stop_valid", dig_valid, 1);
    @(posedge clk);
    #1 stop = 0; streaming = 0;
    chk("stop_valid", dig_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_addr", mem_addr, a);
    repeat (5) @(posedge clk);
    #1 chk("stop_addr_frozen", mem_addr, a);
    do_start(7, 1);
    chk("start_wins_busy", busy, 1);
    chk("start_wins_addr", mem_addr, 7);
    wait_valid(lat);
    chk("start_wins_latency", lat, RD_LAT + 1);
    repeat (6) @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #1 rst = 0; streaming = 0;
    chk_reset_vals("run_reset");
    chk("pre_bad_err", bcd_err, 0);
    bad_k = 5;
    do_start(5);
    wait_valid(lat);
    chk("bad_latency", lat, RD_LAT + 1);
    chk("bad_err_load", bcd_err, 1);
    chk("bad_dig0", dig, 5);
    repeat (12) @(posedge clk);
    do_start(20);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", bcd_err, 1);
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #1 rst = 0; streaming = 0;
    chk("err_cleared", bcd_err, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pi_digit_stream.md
Name: pi_digit_stream

Overview:
- Sits directly downstream of the pi digit ROM wrapper.
- Drives its word address, tracks its fixed read latency, buffers returned 36-bit words and unpacks each into 9 BCD digits.
- Presents the digits as a valid/ready stream to the screen character stage, at a sustained 1 digit/cycle when the sink is always ready.

Parameters:
- N, 6144: number of words in the ROM; addresses wrap N-1 -> 0.
- ADDR_W, 24: word address width.
- DATA_W, 36: ROM word width, fixed at 9 x 4-bit BCD.
- RD_LAT, 3: cycles from address presented to matching word on mem_data.
- FIFO_DEPTH, 4: word buffer depth, power of 2, >= RD_LAT+1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle pulse: flush and begin streaming from start_addr.
- start_addr  in  ADDR_W  first word index; must be < N.
- stop  in  1  1-cycle pulse: cease issuing reads, drain nothing, go IDLE.
- mem_addr  out  ADDR_W  word address to ROM wrapper.
- mem_data  in  DATA_W  ROM wrapper output.
- dig_valid  out  1  digit available.
- dig_ready  in  1  sink accepts digit.
- dig  out  4  BCD digit.
- dig_first  out  1  digit is the first digit of the word at start_addr.
- bcd_err  out  1  sticky: an unpacked nibble was > 9.
- busy  out  1  state == RUN.

Behaviour:
- Reset (rst high at a clk edge): state IDLE; mem_addr=0; dig_valid=0; dig=0; dig_first=0; bcd_err=0; busy=0. FIFO, tag pipe and unpack counter are cleared.
- A rst during RUN aborts immediately. No digit is emitted on the following cycle.
- Word format: digit 0 = bits[35:32], then down to digit 8 = bits[3:0]. Digits are emitted in that order.
- States: IDLE, RUN.
  - IDLE --start--> RUN.
  - RUN --stop--> IDLE.
  - RUN --start--> RUN (restart).
  - If start and stop are high in the same cycle, start wins.
- Issue rule (RUN only): each cycle the block issues one read when in_flight + fifo_count < FIFO_DEPTH.
  - An issued read sets a 1 in the RD_LAT-deep tag shift register and loads the next address.
  - After the address for N-1, the next address is 0.
  - mem_addr is held when no read is issued.
- Tag pipe: when the tag emerges after RD_LAT cycles, mem_data is pushed into the FIFO. Untagged cycles are ignored. No overflow is possible by construction; assert this in simulation.
- Flush on start or stop:
  - The tag pipe, FIFO and unpack state are cleared in the same cycle.
  - Words already in flight are discarded via the cleared tags.
  - On start, mem_addr <= start_addr and the first read issues that cycle.
  - The first digit therefore appears no earlier than RD_LAT+1 cycles after start.
- Unpack stage:
  - Holds one word and a 0..8 digit counter.
  - dig_valid=1 while a word is held. dig and dig_first are registered outputs.
  - A transfer occurs when dig_valid && dig_ready. The counter then advances.
  - At counter 8 with a transfer, the next FIFO word is loaded in the same cycle. This gives no bubble: 1 digit/cycle.
- Backpressure: while dig_ready=0, dig, dig_first and dig_valid are stable and the counter holds.
- dig_first=1 only for digit 0 of the first word delivered after the most recent start.
- bcd_err is set when a loaded word contains any nibble > 9. It is cleared only by rst.
- A stop while dig_valid=1 drops the pending digit. dig_valid is 0 on the next cycle.

Decomposition:
- Shared package:
  - DIGITS_PER_WORD=9.
  - BCD_W=4.
  - Default N, ADDR_W, DATA_W.
  - State enum {IDLE, RUN}.
- Sub-module: pi_word_fifo. This is a synchronous FIFO with DEPTH/WIDTH parameters, push/pop, count, and synchronous clear (driven by rst|start|stop).

Test Plan:
- Model ROM: RD_LAT=3, word k = k's 9-digit pattern. Set start_addr=0 with dig_ready tied 1 -> first dig_valid exactly 4 cycles after start. Digits 1,4,1,5,9,2,6,5,3 are then continuous with no bubble across 3 words; dig_first only on the first digit.
- Wrap: N=6144, start_addr=6143 -> after the 9 digits of word 6143, the next digit is digit 0 of word 0. mem_addr sequence is 6143, 0, 1.
- Backpressure: toggle dig_ready randomly 50%. Check the digit sequence is identical to the ready=1 run, outputs are stable while stalled, FIFO never overflows, and no read issues when in_flight+count=4.
- Restart mid-stream: start_addr=10 while words 0..3 are in flight -> no digit from words 0..3 appears. The next delivered digit is word 10 digit 0 with dig_first=1.
- Stop, then rst: stop pulse -> dig_valid=0 next cycle, busy=0, mem_addr frozen. Assert rst during RUN -> all outputs take reset values at the next edge.
- BCD error: ROM word with nibble 0xA -> bcd_err=1 from the load cycle. It stays 1 across a start and clears only on rst.
